pc_stack: RTL and testbench

- Parametrised program counter for the next CPU generation.
- Adds relative branches, subroutine call/return through an internal return-address stack (RAS), a stall input and sticky fault reporting.
- Sits in the fetch stage: drives the instruction-memory address and takes control requests from decode.
- Exactly one operation is applied per unstalled clock.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/return_stack.sv | 59 +++++
 rtl/pc_stack.sv | 92 +++++++++
 tb/tb_pc_stack.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: op codes,
// fault codes and the width of the return-stack occupancy counter.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_INC    = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_e;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_OVF  = 2'b01;
    localparam logic [1:0] FAULT_UNF  = 2'b10;

    // Occupancy must be able to hold the value STACK_DEPTH itself.
    function automatic int depth_w(input int stack_depth);
        return $clog2(stack_depth) + 1;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO holding subroutine return addresses. The top entry is read
// combinationally so a return needs no extra cycle. Overflowing pushes
// and underflowing pops are dropped.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [WIDTH-1:0]                  push_data,
    output logic [WIDTH-1:0]                  top,
    output logic [depth_w(STACK_DEPTH)-1:0]   depth,
    output logic                              full,
    output logic                              empty
);

    localparam int DW = depth_w(STACK_DEPTH);
    localparam int PW = DW - 1;
    localparam logic [DW-1:0] FULL_CNT = DW'(STACK_DEPTH);

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    // Depth is a power of two, so the low bits of depth wrap naturally:
    // the write slot is depth, the top slot is depth-1.
    assign wr_idx  = depth[PW-1:0];
    assign top_idx = depth[PW-1:0] - PW'(1);
    assign full    = (depth == FULL_CNT);
    assign empty   = (depth == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top     = mem[top_idx];

    // Occupancy counter; push and pop never arrive together.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
        end else if (do_push) begin
            depth <= depth + DW'(1);
        end else if (do_pop) begin
            depth <= depth - DW'(1);
        end
    end

    // Entry storage; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter with relative branches, call/return via an
// internal return-address stack, stall, and a sticky first-fault record.
module pc_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] INC_STEP     = WIDTH'(1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic [2:0]                        op,
    input  logic [WIDTH-1:0]                  target,
    input  logic [WIDTH-1:0]                  offset,
    input  logic                              cond,
    output logic [WIDTH-1:0]                  pc,
    output logic [depth_w(STACK_DEPTH)-1:0]   depth,
    output logic                              stack_full,
    output logic                              stack_empty,
    output logic                              fault,
    output logic [1:0]                        fault_code
);

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             is_call;
    logic             is_ret;
    logic             push;
    logic             pop;
    logic             ovf;
    logic             unf;

    assign pc_inc  = pc + INC_STEP;
    assign is_call = !stall && (op == OP_CALL);
    assign is_ret  = !stall && (op == OP_RET);
    assign push    = is_call && !stack_full;
    assign pop     = is_ret && !stack_empty;
    assign ovf     = is_call && stack_full;
    assign unf     = is_ret && stack_empty;

    return_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // Next-pc selection; unknown op codes fall through to hold.
    always_comb begin
        pc_next = pc;
        case (op)
            OP_INC:    pc_next = pc_inc;
            OP_JUMP:   pc_next = target;
            OP_BRANCH: pc_next = cond ? (pc + offset) : pc_inc;
            OP_CALL:   pc_next = target;
            OP_RET:    pc_next = stack_empty ? pc_inc : ras_top;
            default:   pc_next = pc;
        endcase
    end

    // Program counter register; stall freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (!stall) begin
            pc <= pc_next;
        end
    end

    // Sticky fault: only the first overflow/underflow is recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else if (!fault && (ovf || unf)) begin
            fault      <= 1'b1;
            fault_code <= ovf ? FAULT_OVF : FAULT_UNF;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

    localparam int WIDTH = 16;
    localparam int STACK_DEPTH = 8;
    localparam logic [15:0] RV = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] target;
    logic [15:0] offset;
    logic        cond;
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        fault;
    logic [1:0]  fault_code;

    int chk_cnt = 0;
    int pass_cnt = 0;

    pc_stack #(
        .WIDTH        (WIDTH),
        .STACK_DEPTH  (STACK_DEPTH),
        .RESET_VECTOR (RV),
        .INC_STEP     (16'd1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .cond        (cond),
        .pc          (pc),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply(input logic [2:0] o, input logic [15:0] t,
                         input logic [15:0] off, input logic c);
        op = o; target = t; offset = off; cond = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(3'd0, 16'h0, 16'h0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (pc !== RV) $display("FAIL reset_pc got=%h exp=%h", pc, RV); else pass_cnt++;
        chk_cnt++;
        if (depth !== 4'd0) $display("FAIL reset_depth got=%0d exp=0", depth); else pass_cnt++;
        chk_cnt++;
        if ({stack_full, stack_empty} !== 2'b01) $display("FAIL reset_flags got=%b exp=01", {stack_full, stack_empty}); else pass_cnt++;
        chk_cnt++;
        if ({fault, fault_code} !== 3'b000) $display("FAIL reset_fault got=%b exp=000", {fault, fault_code}); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_inc();
        logic [15:0] exp;
        for (int i = 1; i <= 3; i++) begin
            apply(3'd1, 16'h0, 16'h0, 1'b0);
            exp = RV + 16'(i);
            if (pc !== exp) $display("FAIL inc_%0d got=%h exp=%h", i, pc, exp); else pass_cnt++;
            chk_cnt++;
        end
        if (stack_empty !== 1'b1) $display("FAIL inc_empty got=%b exp=1", stack_empty); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_branch_wrap();
        apply(3'd2, 16'h0010, 16'h0, 1'b0);
        if (pc !== 16'h0010) $display("FAIL jump got=%h exp=0010", pc); else pass_cnt++;
        chk_cnt++;
        apply(3'd3, 16'h0, 16'hFFF8, 1'b1);
        if (pc !== 16'h0008) $display("FAIL branch_taken got=%h exp=0008", pc); else pass_cnt++;
        chk_cnt++;
        apply(3'd3, 16'h0, 16'hFFF8, 1'b0);
        if (pc !== 16'h0009) $display("FAIL branch_not_taken got=%h exp=0009", pc); else pass_cnt++;
        chk_cnt++;
        apply(3'd6, 16'h1234, 16'h0004, 1'b1);
        apply(3'd7, 16'h1234, 16'h0004, 1'b1);
        apply(3'd0, 16'h1234, 16'h0004, 1'b1);
        if (pc !== 16'h0009) $display("FAIL nop_codes got=%h exp=0009", pc); else pass_cnt++;
        chk_cnt++;
        apply(3'd2, 16'hFFFF, 16'h0, 1'b0);
        apply(3'd1, 16'h0, 16'h0, 1'b0);
        if (pc !== 16'h0000) $display("FAIL inc_wrap got=%h exp=0000", pc); else pass_cnt++;
        chk_cnt++;
        if (fault !== 1'b0) $display("FAIL wrap_fault got=%b exp=0", fault); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_nested_call();
        do_reset();
        apply(3'd2, 16'h0020, 16'h0, 1'b0);
        apply(3'd4, 16'h0200, 16'h0, 1'b0);
        if (pc !== 16'h0200 || depth !== 4'd1) $display("FAIL call1 got=%h/%0d exp=0200/1", pc, depth); else pass_cnt++;
        chk_cnt++;
        apply(3'd4, 16'h0300, 16'h0, 1'b0);
        if (pc !== 16'h0300 || depth !== 4'd2) $display("FAIL call2 got=%h/%0d exp=0300/2", pc, depth); else pass_cnt++;
        chk_cnt++;
        apply(3'd5, 16'h0, 16'h0, 1'b0);
        if (pc !== 16'h0201 || depth !== 4'd1) $display("FAIL ret1 got=%h/%0d exp=0201/1", pc, depth); else pass_cnt++;
        chk_cnt++;
        apply(3'd5, 16'h0, 16'h0, 1'b0);
        if (pc !== 16'h0021 || depth !== 4'd0) $display("FAIL ret2 got=%h/%0d exp=0021/0", pc, depth); else pass_cnt++;
        chk_cnt++;
        if (fault !== 1'b0 || stack_empty !== 1'b1) $display("FAIL nested_clean got=%b/%b exp=0/1", fault, stack_empty); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_overflow();
        logic [15:0] t;
        do_reset();
        apply(3'd2, 16'h1000, 16'h0, 1'b0);
        // Call i jumps to 0x1000 + i*0x100 and pushes the previous pc + 1.
        for (int i = 1; i <= 8; i++) begin
            t = 16'h1000 + 16'(i * 256);
            apply(3'd4, t, 16'h0, 1'b0);
            if (pc !== t || depth !== 4'(i)) $display("FAIL ovf_call_%0d got=%h/%0d exp=%h/%0d", i, pc, depth, t, i); else pass_cnt++;
            chk_cnt++;
        end
        if (stack_full !== 1'b1 || fault !== 1'b0) $display("FAIL full_no_fault got=%b/%b exp=1/0", stack_full, fault); else pass_cnt++;
        chk_cnt++;
        apply(3'd4, 16'h1900, 16'h0, 1'b0);
        if (pc !== 16'h1900 || depth !== 4'd8) $display("FAIL ovf_call_9 got=%h/%0d exp=1900/8", pc, depth); else pass_cnt++;
        chk_cnt++;
        if (stack_full !== 1'b1 || fault !== 1'b1 || fault_code !== 2'b01) $display("FAIL ovf_fault got=%b/%b/%b exp=1/1/01", stack_full, fault, fault_code); else pass_cnt++;
        chk_cnt++;
        apply(3'd5, 16'h0, 16'h0, 1'b0);
        if (pc !== 16'h1701 || depth !== 4'd7 || stack_full !== 1'b0) $display("FAIL ovf_ret got=%h/%0d/%b exp=1701/7/0", pc, depth, stack_full); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_underflow();
        do_reset();
        apply(3'd2, 16'h0040, 16'h0, 1'b0);
        apply(3'd5, 16'h0, 16'h0, 1'b0);
        if (pc !== 16'h0041 || depth !== 4'd0) $display("FAIL unf_ret got=%h/%0d exp=0041/0", pc, depth); else pass_cnt++;
        chk_cnt++;
        if (fault !== 1'b1 || fault_code !== 2'b10) $display("FAIL unf_fault got=%b/%b exp=1/10", fault, fault_code); else pass_cnt++;
        chk_cnt++;
        for (int i = 0; i < 9; i++) apply(3'd4, 16'h0800, 16'h0, 1'b0);
        if (depth !== 4'd8 || fault_code !== 2'b10) $display("FAIL unf_sticky got=%0d/%b exp=8/10", depth, fault_code); else pass_cnt++;
        chk_cnt++;
        do_reset();
        if (fault !== 1'b0 || fault_code !== 2'b00) $display("FAIL unf_reset got=%b/%b exp=0/00", fault, fault_code); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        apply(3'd4, 16'h0500, 16'h0, 1'b0);
        apply(3'd4, 16'h0600, 16'h0, 1'b0);
        apply(3'd4, 16'h0700, 16'h0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(3'd4, 16'h0900, 16'h0, 1'b0);
            if (pc !== 16'h0700 || depth !== 4'd3) $display("FAIL stall_%0d got=%h/%0d exp=0700/3", i, pc, depth); else pass_cnt++;
            chk_cnt++;
        end
        reset = 1'b1;
        apply(3'd4, 16'h0900, 16'h0, 1'b0);
        reset = 1'b0;
        stall = 1'b0;
        if (pc !== RV || depth !== 4'd0) $display("FAIL stall_reset got=%h/%0d exp=%h/0", pc, depth, RV); else pass_cnt++;
        chk_cnt++;
        // A stalled return on an empty stack must not be treated as underflow.
        stall = 1'b1;
        apply(3'd5, 16'h0, 16'h0, 1'b0);
        stall = 1'b0;
        if (pc !== RV || fault !== 1'b0) $display("FAIL stall_ret got=%h/%b exp=%h/0", pc, fault, RV); else pass_cnt++;
        chk_cnt++;
        // Stalled cycles must leave stack contents intact.
        apply(3'd4, 16'h0A00, 16'h0, 1'b0);
        stall = 1'b1;
        apply(3'd4, 16'h0B00, 16'h0, 1'b0);
        stall = 1'b0;
        apply(3'd5, 16'h0, 16'h0, 1'b0);
        if (pc !== 16'h0101 || depth !== 4'd0) $display("FAIL stall_ras got=%h/%0d exp=0101/0", pc, depth); else pass_cnt++;
        chk_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        op = 3'd0;
        target = '0;
        offset = '0;
        cond = 1'b0;
        #2;
        test_reset();
        test_inc();
        test_branch_wrap();
        test_nested_call();
        test_overflow();
        test_underflow();
        test_stall();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
